// File: rtl/sound_beeper_if.sv
// rtl/sound_beeper_if.sv - request/tone bus between a beep requester and the sound_beeper sequencer
interface sound_beeper_if #(
    parameter int DIV_W = 52
);
    logic             enable;
    logic             short;
    logic             long;
    logic [DIV_W-1:0] div_in;
    logic             s_enable;
    logic             tone;
    logic             busy;
    logic [DIV_W-1:0] sonido;

    modport master (
        output enable, short, long, div_in,
        input  s_enable, tone, busy, sonido
    );

    modport slave (
        input  enable, short, long, div_in,
        output s_enable, tone, busy, sonido
    );
endinterface

// File: rtl/sound_beeper.sv
// rtl/sound_beeper.sv - turns short/long beep requests into timed square-wave tone bursts with a silence gap
// Optional macro SOUND_QUEUE_EN: one-deep pending request so a beep can follow the previous one without an IDLE cycle.
module sound_beeper #(
    parameter int              DIV_W        = 52,
    parameter longint unsigned DEFAULT_DIV  = 32000,
    parameter int              CNT_W        = 24,
    parameter int              SHORT_CYCLES = 5000000,
    parameter int              LONG_CYCLES  = 15000000,
    parameter int              GAP_CYCLES   = 2500000
) (
    input  logic          clk,
    input  logic          reset,
    sound_beeper_if.slave bus
);

    localparam longint unsigned CNT_LIMIT = 64'd1 << CNT_W;
    localparam logic [CNT_W-1:0] SHORT_LEN = CNT_W'(SHORT_CYCLES);
    localparam logic [CNT_W-1:0] LONG_LEN  = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam logic [DIV_W-1:0] DEF_DIV   = DIV_W'(DEFAULT_DIV);

    if (SHORT_CYCLES < 1 || LONG_CYCLES < 1 || GAP_CYCLES < 0 ||
        longint'(SHORT_CYCLES) >= longint'(CNT_LIMIT) ||
        longint'(LONG_CYCLES)  >= longint'(CNT_LIMIT) ||
        longint'(GAP_CYCLES)   >= longint'(CNT_LIMIT)) begin : g_len_check
        $error("sound_beeper: burst/gap lengths must be in 1..2**CNT_W-1 (gap may be 0)");
    end

    typedef enum logic [1:0] {
        IDLE,
        TONE,
        GAP
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] hc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_q;
    logic [DIV_W-1:0] sonido_q;
    logic             s_enable_q;
    logic             tone_q;
    logic             busy_q;

    logic             req;
    logic [DIV_W-1:0] div_sel;
    logic             tone_last;
    logic             gap_last;
    logic             start;
    logic             start_long;

`ifdef SOUND_QUEUE_EN
    logic pend_valid;
    logic pend_long;
    logic beep_done;
`endif

    always_comb begin
        req        = bus.short || bus.long;
        div_sel    = (bus.div_in == '0) ? DEF_DIV : bus.div_in;
        tone_last  = (state == TONE) && (cnt == len_q - 1'b1);
        gap_last   = (state == GAP) && (cnt == GAP_LAST);
        start      = (state == IDLE) && req;
        start_long = bus.long;
`ifdef SOUND_QUEUE_EN
        // A request arriving on the very last busy cycle counts as pending too.
        beep_done = gap_last || (tone_last && (GAP_CYCLES == 0));
        if (beep_done && (pend_valid || req)) begin
            start      = 1'b1;
            start_long = pend_valid ? pend_long : bus.long;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hc         <= '0;
            cnt        <= '0;
            len_q      <= '0;
            sonido_q   <= DEF_DIV;
            s_enable_q <= 1'b0;
            tone_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef SOUND_QUEUE_EN
            pend_valid <= 1'b0;
            pend_long  <= 1'b0;
`endif
        end else if (!bus.enable) begin
            state      <= IDLE;
            hc         <= '0;
            cnt        <= '0;
            s_enable_q <= 1'b0;
            tone_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef SOUND_QUEUE_EN
            pend_valid <= 1'b0;
`endif
        end else if (start) begin
            state      <= TONE;
            hc         <= '0;
            cnt        <= '0;
            len_q      <= start_long ? LONG_LEN : SHORT_LEN;
            sonido_q   <= div_sel;
            s_enable_q <= 1'b1;
            tone_q     <= 1'b1;
            busy_q     <= 1'b1;
`ifdef SOUND_QUEUE_EN
            pend_valid <= 1'b0;
`endif
        end else begin
            case (state)
                TONE: begin
                    if (tone_last) begin
                        hc         <= '0;
                        cnt        <= '0;
                        s_enable_q <= 1'b0;
                        tone_q     <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            state <= GAP;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        // Half-period counter: toggle once every sonido cycles.
                        if (hc == sonido_q - 1'b1) begin
                            tone_q <= ~tone_q;
                            hc     <= '0;
                        end else begin
                            hc <= hc + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_last) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
`ifdef SOUND_QUEUE_EN
            if (state != IDLE && req && !pend_valid) begin
                pend_valid <= 1'b1;
                pend_long  <= bus.long;
            end
`endif
        end
    end

    assign bus.s_enable = s_enable_q;
    assign bus.tone     = tone_q;
    assign bus.busy     = busy_q;
    assign bus.sonido   = sonido_q;

endmodule
